// File: rtl/rf_check_seq.sv
// Register-file self-check sequencer: after start and a settle delay, reads each enabled table entry
// via the debug port one cycle ahead of the compare. Optional RF_CHECK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module rf_check_seq #(
  parameter int XLEN        = 32,
  parameter int NUM_CHECKS  = 8,
  parameter int WAIT_CYCLES = 30,
  parameter int RA_W        = 5,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W = $clog2(NUM_CHECKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [RA_W-1:0]  cfg_regnum,
  input  logic [XLEN-1:0]  cfg_expected,
  output logic [RA_W-1:0]  dbg_raddr,
  input  logic [XLEN-1:0]  dbg_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] fail_idx,
  output logic [RA_W-1:0]  fail_regnum,
  output logic [XLEN-1:0]  fail_actual
);

`ifdef RF_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_CMP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  err_nxt;
  logic [IDX_W-1:0]  fail_idx_nxt;
  logic [RA_W-1:0]   fail_regnum_nxt;
  logic [XLEN-1:0]   fail_actual_nxt;

  logic [NUM_CHECKS-1:0] tbl_en;
  logic [RA_W-1:0]       tbl_reg [NUM_CHECKS];
  logic [XLEN-1:0]       tbl_exp [NUM_CHECKS];

  logic cfg_ok;
  logic last;
  logic mismatch;

  // Indices beyond the table (non-power-of-two depth) are dropped.
  assign cfg_ok   = (state == S_IDLE) && cfg_we &&
                    ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_CHECKS));
  assign last     = (ptr == IDX_W'(NUM_CHECKS - 1));
  assign mismatch = (dbg_rdata != tbl_exp[ptr]);

  assign busy      = (state == S_WAIT) || (state == S_ADDR) || (state == S_CMP);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_raddr = ((state == S_ADDR) && tbl_en[ptr]) ? tbl_reg[ptr] : '0;

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    ptr_nxt         = ptr;
    err_nxt         = err_count;
    fail_idx_nxt    = fail_idx;
    fail_regnum_nxt = fail_regnum;
    fail_actual_nxt = fail_actual;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt       = S_WAIT;
          wait_cnt_nxt    = 16'(WAIT_CYCLES);
          ptr_nxt         = '0;
          err_nxt         = '0;
          fail_idx_nxt    = '0;
          fail_regnum_nxt = '0;
          fail_actual_nxt = '0;
        end
      end
      // Leaving at a count of 1 gives WAIT_CYCLES cycles here, and a zero setting still spends one.
      S_WAIT: begin
        if (wait_cnt <= 16'd1) begin
          state_nxt = S_ADDR;
          ptr_nxt   = '0;
        end else begin
          wait_cnt_nxt = wait_cnt - 16'd1;
        end
      end
      S_ADDR: begin
        if (tbl_en[ptr]) begin
          state_nxt = S_CMP;
        end else if (last) begin
          state_nxt = S_DONE;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      S_CMP: begin
        if (mismatch) begin
          if (err_count == '0) begin
            fail_idx_nxt    = ptr;
            fail_regnum_nxt = tbl_reg[ptr];
            fail_actual_nxt = dbg_rdata;
          end
          if (err_count != CNT_W'(NUM_CHECKS)) begin
            err_nxt = err_count + 1'b1;
          end
        end
        if (last || (STOP_ON_FAIL && mismatch)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ADDR;
          ptr_nxt   = ptr + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ptr         <= '0;
      err_count   <= '0;
      fail_idx    <= '0;
      fail_regnum <= '0;
      fail_actual <= '0;
      tbl_en      <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      ptr         <= ptr_nxt;
      err_count   <= err_nxt;
      fail_idx    <= fail_idx_nxt;
      fail_regnum <= fail_regnum_nxt;
      fail_actual <= fail_actual_nxt;
      if (cfg_ok) begin
        tbl_en[cfg_idx] <= cfg_en;
      end
    end
  end

  // Payload fields are only read behind a set enable bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_reg[cfg_idx] <= cfg_regnum;
      tbl_exp[cfg_idx] <= cfg_expected;
    end
  end

endmodule

// File: tb/tb_rf_check_seq.sv
// Bench for rf_check_seq: directed runs push expected results into a scoreboard; a forked monitor checks them when done rises.
module tb_rf_check_seq;
  localparam int XLEN        = 32;
  localparam int NUM_CHECKS  = 8;
  localparam int WAIT_CYCLES = 30;
  localparam int RA_W        = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic [4:0]  cfg_regnum = '0;
  logic [31:0] cfg_expected = '0;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy, done, pass;
  logic [3:0]  err_count;
  logic [2:0]  fail_idx;
  logic [4:0]  fail_regnum;
  logic [31:0] fail_actual;

  logic [31:0] rf [32];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pass_e;
    logic [31:0] err;
    logic [31:0] fidx;
    logic [31:0] freg;
    logic [31:0] fact;
    logic [31:0] lat;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];

  rf_check_seq #(
    .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .WAIT_CYCLES(WAIT_CYCLES), .RA_W(RA_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_regnum(cfg_regnum), .cfg_expected(cfg_expected),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_idx(fail_idx), .fail_regnum(fail_regnum), .fail_actual(fail_actual)
  );

  always #5 clk = ~clk;

  // Register-file model with one cycle of read latency.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    dbg_rdata <= rf[dbg_raddr];
  end

  function automatic exp_t mk(input logic p, input int err, input int fi, input int fr,
                              input logic [31:0] fa, input int lat, input logic [31:0] mask);
    exp_t e;
    e.pass_e = 32'(p);
    e.err    = 32'(err);
    e.fidx   = 32'(fi);
    e.freg   = 32'(fr);
    e.fact   = fa;
    e.lat    = 32'(lat);
    e.mask   = mask;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Latency counts from the cycle start is driven to the first cycle done is high.
  task automatic monitor();
    logic        done_q;
    int          start_cyc;
    logic [31:0] seen;
    exp_t        e;
    done_q = 1'b0;
    start_cyc = 0;
    seen = '0;
    forever begin
      @(negedge clk);
      if (start && !busy) begin
        start_cyc = cyc;
        seen = '0;
      end
      if (dbg_raddr != '0) seen[dbg_raddr] = 1'b1;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
        end else begin
          e = sb.pop_front();
          chk("pass",        64'(pass),        64'(e.pass_e));
          chk("err_count",   64'(err_count),   64'(e.err));
          chk("fail_idx",    64'(fail_idx),    64'(e.fidx));
          chk("fail_regnum", 64'(fail_regnum), 64'(e.freg));
          chk("fail_actual", 64'(fail_actual), 64'(e.fact));
          chk("run_length",  64'(cyc - start_cyc), 64'(e.lat));
          chk("raddr_set",   64'(seen),        64'(e.mask));
        end
      end
      done_q = done;
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [4:0] rn, input logic [31:0] ev);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_regnum = rn; cfg_expected = ev;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input exp_t e, input bit track);
    if (track) sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen, %0d results outstanding", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_base();
    cfg_write(3'd0, 1'b1, 5'd1, 32'h0000_1000);
    cfg_write(3'd1, 1'b1, 5'd2, 32'h0000_2004);
    cfg_write(3'd2, 1'b1, 5'd3, 32'hFFFF_F008);
    cfg_write(3'd3, 1'b1, 5'd4, 32'h0000_000C);
  endtask

  task automatic rf_good();
    rf[1] = 32'h0000_1000;
    rf[2] = 32'h0000_2004;
    rf[3] = 32'hFFFF_F008;
    rf[4] = 32'h0000_000C;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},        64'(busy),        64'd0);
    chk({tag, "_done"},        64'(done),        64'd0);
    chk({tag, "_pass"},        64'(pass),        64'd0);
    chk({tag, "_err_count"},   64'(err_count),   64'd0);
    chk({tag, "_fail_idx"},    64'(fail_idx),    64'd0);
    chk({tag, "_fail_regnum"}, 64'(fail_regnum), 64'd0);
    chk({tag, "_fail_actual"}, 64'(fail_actual), 64'd0);
    chk({tag, "_dbg_raddr"},   64'(dbg_raddr),   64'd0);
  endtask

  // Entries 0..3 enabled, 4..7 skipped at one cycle each: 1 + 30 + 4*2 + 4 = 43.
  exp_t e_all_ok;
  exp_t e_x3_bad;
  exp_t e_x2x4_bad;
  exp_t e_none;
  exp_t e_sparse;
  exp_t e_x0;

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf_good();
    rf[7] = 32'h0000_0077;
    rf[9] = 32'h0000_0099;

    e_all_ok = mk(1'b1, 0, 0, 0, 32'h0, 43, 32'h0000_001E);
`ifdef RF_CHECK_STOP_ON_FAIL_EN
    e_x3_bad   = mk(1'b0, 1, 2, 3, 32'hFFFF_F000, 37, 32'h0000_000E);
    e_x2x4_bad = mk(1'b0, 1, 1, 2, 32'h0000_2000, 35, 32'h0000_0006);
`else
    e_x3_bad   = mk(1'b0, 1, 2, 3, 32'hFFFF_F000, 43, 32'h0000_001E);
    e_x2x4_bad = mk(1'b0, 2, 1, 2, 32'h0000_2000, 43, 32'h0000_001E);
`endif
    e_none   = mk(1'b1, 0, 0, 0, 32'h0, 39, 32'h0);
    e_sparse = mk(1'b1, 0, 0, 0, 32'h0, 41, 32'h0000_0280);
    e_x0     = mk(1'b0, 1, 7, 0, 32'h0, 40, 32'h0);

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    load_base();
    pulse_start(e_all_ok, 1'b1);
    wait_idle("all_ok");

    rf[3] = 32'hFFFF_F000;
    pulse_start(e_x3_bad, 1'b1);
    wait_idle("x3_bad");

    rf_good();
    rf[2] = 32'h0000_2000;
    rf[4] = 32'h0000_0008;
    pulse_start(e_x2x4_bad, 1'b1);
    wait_idle("x2x4_bad");

    // start and table writes during WAIT must change nothing.
    rf_good();
    pulse_start(e_all_ok, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_done", 64'(done), 64'd0);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_regnum = 5'd1; cfg_expected = 32'h0000_DEAD;
    @(posedge clk); #1;
    cfg_idx = 3'd4; cfg_regnum = 5'd5; cfg_expected = 32'h0000_5555;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    wait_idle("busy_ignore");

    // Abort in CMP of entry 2.
`ifndef RF_CHECK_STOP_ON_FAIL_EN
    rf[1] = 32'h0000_1001;
`endif
    pulse_start(e_all_ok, 1'b0);
    n = 0;
    while (dbg_raddr != 5'd3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_addr2_raddr", 64'(dbg_raddr), 64'd3);
    @(posedge clk); #1;
    chk("abort_cmp2_busy", 64'(busy), 64'd1);
`ifndef RF_CHECK_STOP_ON_FAIL_EN
    chk("abort_cmp2_err", 64'(err_count), 64'd1);
`endif
    reset = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b1;
    rf_good();
    @(posedge clk); #1;

    // Table enables were cleared by the reset.
    pulse_start(e_none, 1'b1);
    wait_idle("no_entries");

    do_reset();
    load_base();
    pulse_start(e_all_ok, 1'b1);
    wait_idle("after_reset");

    // Entry 5 is written in the same cycle as start.
    do_reset();
    cfg_write(3'd0, 1'b1, 5'd7, 32'h0000_0077);
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_en = 1'b1; cfg_regnum = 5'd9; cfg_expected = 32'h0000_0099;
    pulse_start(e_sparse, 1'b1);
    wait_idle("sparse");

    do_reset();
    cfg_write(3'd7, 1'b1, 5'd0, 32'h0000_0001);
    pulse_start(e_x0, 1'b1);
    wait_idle("x0_entry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
